// File: rtl/user_proj_example_wb.sv
// Wishbone-slave nearest-patch search engine: a 6-level KD tree descent picks a leaf,
// then an L1 scan over the leaf's 8 patches selects the best-matching patch index.
module user_proj_example_wb #(
    parameter int BITS       = 32,
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = 494
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [BITS-1:0]  wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [BITS-1:0]  wbs_dat_o,
    input  logic [127:0]     la_data_in,
    output logic [127:0]     la_data_out,
    input  logic [127:0]     la_oenb,
    input  logic [37:0]      io_in,
    output logic [37:0]      io_out,
    output logic [37:0]      io_oeb,
    output logic [2:0]       irq
);
    localparam int Q_ROWS    = NUM_QUERYS * PATCH_SIZE;
    localparam int L_ROWS    = NUM_LEAVES * LEAF_SIZE * PATCH_SIZE;
    localparam int NUM_NODES = NUM_LEAVES - 1;
    localparam logic [11:0] Q_ROWS_W = 12'(Q_ROWS);
    localparam logic [11:0] L_ROWS_W = 12'(L_ROWS);
    localparam logic [11:0] NQ_W     = 12'(NUM_QUERYS);
    localparam logic [8:0]  Q_LAST   = 9'(NUM_QUERYS - 1);

    typedef logic [DATA_WIDTH-1:0] pix_t;
    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_DIST, S_NEXT, S_DONE} state_t;

    function automatic pix_t get_pix(input logic [63:0] w, input logic [2:0] c);
        case (c)
            3'd0:    get_pix = w[10:0];
            3'd1:    get_pix = w[21:11];
            3'd2:    get_pix = w[32:22];
            3'd3:    get_pix = w[43:33];
            3'd4:    get_pix = w[54:44];
            default: get_pix = 11'd0;
        endcase
    endfunction

    function automatic logic [13:0] row_l1(input logic [63:0] a, input logic [63:0] b);
        logic [13:0] s;
        pix_t        x;
        pix_t        y;
        s = 14'd0;
        for (int c = 0; c < 5; c++) begin
            x = get_pix(a, 3'(c));
            y = get_pix(b, 3'(c));
            s = s + 14'((x > y) ? (x - y) : (y - x));
        end
        return s;
    endfunction

    logic [63:0] qmem_q [Q_ROWS];
    logic [63:0] lmem_q [L_ROWS];
    logic [15:0] nmem_q [NUM_NODES+1];
    logic [10:0] bmem_q [NUM_QUERYS];

    logic        ack_q, mode_q, debug_q, busy_q, busy_d, done_q, done_d;
    logic [31:0] dat_q, rd_data_s;
    state_t      state_q, state_d;
    logic [8:0]  q_q, q_d, best_idx_q, best_idx_d, cur_idx_q, cur_idx_d;
    logic [6:0]  n_q, n_d;
    logic [2:0]  step_q, step_d, slot_q, slot_d, row_q, row_d;
    logic [15:0] acc_q, acc_d, best_dist_q, best_dist_d, tot_s;

    logic        req_s, wr_s, start_s, go_right_s, unused_s;
    logic [15:0] region_s, offs_s, node_s;
    logic [11:0] wrow_s, q_addr_s, l_addr_s;
    logic [2:0]  e_row_s, e_col_s, q_row_sel_s;
    logic [63:0] q_word_s, l_word_s;
    logic [13:0] row_dist_s;
    pix_t        pix_s;

    assign region_s = wbs_adr_i[31:16];
    assign offs_s   = wbs_adr_i[15:0];
    assign wrow_s   = wbs_adr_i[14:3];
    assign req_s    = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_s     = req_s & wbs_we_i & ~busy_q;
    assign start_s  = req_s & wbs_we_i & ~busy_q & (region_s == 16'h3000) & (offs_s == 16'h000C);

    // Datapath: SEARCH addresses the query row holding the node's element, DIST walks rows.
    assign node_s      = nmem_q[n_q[5:0]];
    assign e_row_s     = 3'(node_s[15:11] / 5'd5);
    assign e_col_s     = 3'(node_s[15:11] % 5'd5);
    assign q_row_sel_s = (state_q == S_SEARCH) ? e_row_s : row_q;
    assign q_addr_s    = ({3'd0, q_q} * 12'd5) + {9'd0, q_row_sel_s};
    assign q_word_s    = qmem_q[q_addr_s];
    assign pix_s       = get_pix(q_word_s, e_col_s);
    assign go_right_s  = (pix_s >= node_s[10:0]);
    assign l_addr_s    = ({3'd0, n_q[5:0], slot_q} * 12'd5) + {9'd0, row_q};
    assign l_word_s    = lmem_q[l_addr_s];
    assign row_dist_s  = row_l1(q_word_s, l_word_s);
    assign tot_s       = acc_q + {2'd0, row_dist_s};

    // Wishbone read mux
    always_comb begin
        rd_data_s = 32'h0;
        case (region_s)
            16'h3000: begin
                case (offs_s)
                    16'h0000: rd_data_s = {31'h0, mode_q};
                    16'h0004: rd_data_s = {31'h0, debug_q};
                    16'h0008: rd_data_s = {31'h0, done_q};
                    16'h0010: rd_data_s = {31'h0, busy_q};
                    default:  rd_data_s = 32'h0;
                endcase
            end
            16'h3003: begin
                if (wrow_s < NQ_W) rd_data_s = {21'h0, bmem_q[wrow_s[8:0]]};
                else               rd_data_s = 32'h0;
            end
            default: rd_data_s = 32'h0;
        endcase
    end

    // Bus handshake, read data and control registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            mode_q  <= 1'b0;
            debug_q <= 1'b0;
        end else begin
            ack_q <= req_s;
            if (req_s && !wbs_we_i) dat_q <= rd_data_s;
            if (req_s && wbs_we_i && region_s == 16'h3000 && offs_s == 16'h0000) mode_q  <= wbs_dat_i[0];
            if (req_s && wbs_we_i && region_s == 16'h3000 && offs_s == 16'h0004) debug_q <= wbs_dat_i[0];
        end
    end

    // Host-loaded memories; contents survive reset
    always_ff @(posedge wb_clk_i) begin
        if (wr_s && region_s == 16'h3001 && wrow_s < Q_ROWS_W) begin
            if (wbs_adr_i[2]) qmem_q[wrow_s][63:32] <= wbs_dat_i;
            else              qmem_q[wrow_s][31:0]  <= wbs_dat_i;
        end
        if (wr_s && region_s == 16'h3002 && wrow_s < L_ROWS_W) begin
            if (wbs_adr_i[2]) lmem_q[wrow_s][63:32] <= wbs_dat_i;
            else              lmem_q[wrow_s][31:0]  <= wbs_dat_i;
        end
        if (wr_s && region_s == 16'h3004 && wbs_adr_i[5:0] != 6'd0)
            nmem_q[wbs_adr_i[5:0]] <= {wbs_dat_i[4:0], wbs_dat_i[21:11]};
    end

    // Result memory
    always_ff @(posedge wb_clk_i) begin
        if (state_q == S_NEXT) bmem_q[q_q] <= {2'b00, best_idx_q};
    end

    // Engine state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            q_q         <= 9'd0;
            n_q         <= 7'd1;
            step_q      <= 3'd0;
            slot_q      <= 3'd0;
            row_q       <= 3'd0;
            acc_q       <= 16'd0;
            best_dist_q <= 16'hFFFF;
            best_idx_q  <= 9'd0;
            cur_idx_q   <= 9'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            n_q         <= n_d;
            step_q      <= step_d;
            slot_q      <= slot_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            best_dist_q <= best_dist_d;
            best_idx_q  <= best_idx_d;
            cur_idx_q   <= cur_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Engine next state: 6 cycles descent, 40 cycles leaf scan, 1 cycle write-back per query
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        n_d         = n_q;
        step_d      = step_q;
        slot_d      = slot_q;
        row_d       = row_q;
        acc_d       = acc_q;
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        cur_idx_d   = cur_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_SEARCH;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    q_d     = 9'd0;
                    n_d     = 7'd1;
                    step_d  = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                n_d    = {n_q[5:0], go_right_s};
                step_d = step_q + 3'd1;
                if (step_q == 3'd5) begin
                    state_d     = S_DIST;
                    slot_d      = 3'd0;
                    row_d       = 3'd0;
                    acc_d       = 16'd0;
                    best_dist_d = 16'hFFFF;
                end else begin
                    state_d = S_SEARCH;
                end
            end
            S_DIST: begin
                if (row_q == 3'd0) cur_idx_d = l_word_s[63:55];
                else               cur_idx_d = cur_idx_q;
                if (row_q == 3'd4) begin
                    row_d = 3'd0;
                    acc_d = 16'd0;
                    if (tot_s < best_dist_q) begin
                        best_dist_d = tot_s;
                        best_idx_d  = cur_idx_q;
                    end else begin
                        best_dist_d = best_dist_q;
                    end
                    if (slot_q == 3'd7) state_d = S_NEXT;
                    else                slot_d  = slot_q + 3'd1;
                end else begin
                    row_d = row_q + 3'd1;
                    acc_d = tot_s;
                end
            end
            S_NEXT: begin
                if (q_q == Q_LAST) begin
                    state_d = S_DONE;
                end else begin
                    q_d     = q_q + 9'd1;
                    n_d     = 7'd1;
                    step_d  = 3'd0;
                    state_d = S_SEARCH;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign la_data_out = 128'h0;
    assign io_out      = {6'h00, done_q, busy_q, 30'h0};
    assign io_oeb      = {6'h3F, 2'b00, 30'h3FFF_FFFF};
    assign irq         = {2'b00, done_q};
    assign unused_s    = ^{la_data_in, la_oenb, io_in, wbs_sel_i, n_q[6], q_word_s[63:55]};

endmodule

// File: tb/tb_user_proj_example_wb.sv
// Directed + randomized bench for the KD-tree patch search engine, checked against
// a plain-arithmetic model of tree descent and L1 leaf search.
module tb_user_proj_example_wb;
    logic         clk = 1'b0;
    logic         rst, cyc, stb, we, ack;
    logic [3:0]   sel;
    logic [31:0]  dat_i, adr, dat_o;
    logic [127:0] la_in, la_out, la_oenb;
    logic [37:0]  io_in, io_out, io_oeb;
    logic [2:0]   irq;

    int errors = 0;
    int checks = 0;
    int qpix [494][25];
    int lpix [64][8][25];
    int lidx [64][8];
    int ne [64];
    int nm [64];
    logic [31:0] rd;

    always #5 clk = ~clk;

    user_proj_example_wb dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .la_data_in(la_in), .la_data_out(la_out), .la_oenb(la_oenb),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is positioned at a negative edge; returns at a negative edge.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
        int cnt;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        cnt = 0;
        @(negedge clk);
        while (!ack && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("ack_rise", 64'(ack), 64'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 64'(ack), 64'd0);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_xfer(1'b0, a, 32'h0, r);
    endtask

    function automatic logic [63:0] pack_q(input int q, input int r);
        logic [63:0] w;
        w = 64'd0;
        for (int c = 0; c < 5; c++) w[11*c +: 11] = 11'(qpix[q][r*5+c]);
        return w;
    endfunction

    function automatic logic [63:0] pack_l(input int l, input int s, input int r);
        logic [63:0] w;
        w = 64'd0;
        for (int c = 0; c < 5; c++) w[11*c +: 11] = 11'(lpix[l][s][r*5+c]);
        w[63:55] = (r == 0) ? 9'(lidx[l][s]) : 9'($urandom);
        return w;
    endfunction

    task automatic wr_row(input logic [31:0] base, input int w, input logic [63:0] d);
        wb_write(base | (32'(w) << 3), d[31:0]);
        wb_write(base | (32'(w) << 3) | 32'h4, d[63:32]);
    endtask

    task automatic load_query(input int q);
        for (int r = 0; r < 5; r++) wr_row(32'h3001_0000, q*5 + r, pack_q(q, r));
    endtask

    task automatic load_leaf(input int l);
        for (int s = 0; s < 8; s++)
            for (int r = 0; r < 5; r++) wr_row(32'h3002_0000, (l*8 + s)*5 + r, pack_l(l, s, r));
    endtask

    task automatic load_nodes();
        for (int n = 1; n < 64; n++) wb_write(32'h3004_0000 | 32'(n), (32'(nm[n]) << 11) | 32'(ne[n]));
    endtask

    function automatic int model_best(input int q);
        int n, leaf, bd, bi, d, df;
        n = 1;
        for (int s = 0; s < 6; s++) n = (qpix[q][ne[n]] < nm[n]) ? 2*n : 2*n + 1;
        leaf = n - 64;
        bd = 32'h7FFF_FFFF;
        bi = 0;
        for (int s = 0; s < 8; s++) begin
            d = 0;
            for (int k = 0; k < 25; k++) begin
                df = qpix[q][k] - lpix[leaf][s][k];
                d += (df < 0) ? -df : df;
            end
            if (d < bd) begin
                bd = d;
                bi = lidx[leaf][s];
            end
        end
        return bi;
    endfunction

    task automatic wait_done(input int bound);
        int cnt;
        cnt = 0;
        while (!io_out[31] && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
        check("done_in_time", 64'(io_out[31]), 64'd1);
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; dat_i = 32'h0; adr = 32'h0;
        la_in = 128'h0; la_oenb = 128'h0; io_in = 38'h0;
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check("rst_io_out", 64'(io_out), 64'd0);
        check("rst_io_oeb", 64'(io_oeb), 64'h3F_3FFF_FFFF);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_la", 64'(la_out), 64'd0);
        rst = 1'b0;

        wb_write(32'h3000_0004, 32'h1);
        wb_write(32'h3000_0000, 32'h1);
        wb_read(32'h3000_0004, rd); check("debug_rb", 64'(rd), 64'd1);
        wb_read(32'h3000_0000, rd); check("mode_rb", 64'(rd), 64'd1);
        wb_read(32'h3000_0008, rd); check("done_idle", 64'(rd), 64'd0);
        wb_read(32'h3000_0010, rd); check("busy_idle", 64'(rd), 64'd0);
        wb_read(32'h3000_0014, rd); check("reg_other", 64'(rd), 64'd0);

        // Run 1: every node splits on pixel 0 at 1024 -> >=1024 reaches leaf 63, below reaches leaf 0
        for (int n = 1; n < 64; n++) begin ne[n] = 0; nm[n] = 1024; end
        for (int q = 0; q < 3; q++)
            for (int k = 0; k < 25; k++) qpix[q][k] = $urandom_range(100, 1000);
        qpix[0][0] = 1024;
        qpix[2][0] = 1023;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 25; k++) begin
                lpix[63][s][k] = qpix[0][k];
                lpix[0][s][k]  = qpix[1][k];
            end
            lidx[63][s] = $urandom_range(0, 511);
            lidx[0][s]  = $urandom_range(0, 511);
            if (s != 3) lpix[63][s][$urandom_range(0, 24)] += $urandom_range(1, 50);
            if (s != 2 && s != 5) lpix[0][s][7] += 50;
        end
        lidx[63][3] = 32'h1A5;
        lpix[0][2][10] += 3;  lidx[0][2] = 32'h0B2;
        lpix[0][5][20] -= 3;  lidx[0][5] = 32'h155;
        load_nodes();
        load_leaf(0);
        load_leaf(63);
        for (int q = 0; q < 3; q++) load_query(q);

        wb_write(32'h3000_000C, 32'h1);
        wb_read(32'h3000_0010, rd); check("busy_run1", 64'(rd), 64'd1);
        check("io_busy", 64'(io_out[30]), 64'd1);
        wb_write(32'h3004_0000, 32'h0000_0007);
        wb_write(32'h3004_0001, 32'h0);
        wb_write(32'h3005_0000, 32'hDEAD_BEEF);
        wb_write(32'h3001_0000 | (32'd10 << 3), 32'h0000_07FF);
        wb_write(32'h3000_000C, 32'h1);
        wb_read(32'h3005_0000, rd); check("unmapped_rd", 64'(rd), 64'd0);
        wait_done(494*64);
        check("io_out_done", 64'(io_out), 64'h00_8000_0000);
        check("irq_done", 64'(irq), 64'd1);
        wb_read(32'h3000_0008, rd); check("done_reg", 64'(rd), 64'd1);
        wb_read(32'h3003_0000, rd); check("best_q0", 64'(rd), 64'h1A5);
        wb_write(32'h3000_0000, 32'h0);
        check("dat_hold", 64'(dat_o), 64'h1A5);
        wb_read(32'h3003_0008, rd); check("best_q1_tie", 64'(rd), 64'h0B2);
        wb_read(32'h3003_0014, rd); check("best_q2_adr2", 64'(rd), 64'(model_best(2)));

        // Run 2: fully random tree, leaves and queries
        for (int n = 1; n < 64; n++) begin ne[n] = $urandom_range(0, 24); nm[n] = $urandom_range(0, 2047); end
        for (int q = 0; q < 494; q++)
            for (int k = 0; k < 25; k++) qpix[q][k] = $urandom_range(0, 2047);
        for (int l = 0; l < 64; l++)
            for (int s = 0; s < 8; s++) begin
                lidx[l][s] = $urandom_range(0, 511);
                for (int k = 0; k < 25; k++) lpix[l][s][k] = $urandom_range(0, 2047);
            end
        load_nodes();
        for (int l = 0; l < 64; l++) load_leaf(l);
        for (int q = 0; q < 494; q++) load_query(q);
        wb_read(32'h3000_0008, rd); check("done_sticky", 64'(rd), 64'd1);
        wb_write(32'h3000_000C, 32'h0);
        check("done_cleared", 64'(io_out[31]), 64'd0);
        wait_done(494*64);
        for (int q = 0; q < 494; q++) begin
            wb_read(32'h3003_0000 | (32'(q) << 3), rd);
            check($sformatf("best_q%0d", q), 64'(rd), 64'(model_best(q)));
        end

        // Run 3: reset in the middle of a search
        wb_write(32'h3000_0000, 32'h1);
        wb_write(32'h3000_000C, 32'h1);
        repeat (100) @(negedge clk);
        check("busy_before_rst", 64'(io_out[30]), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_io_out", 64'(io_out), 64'd0);
        check("midrst_irq", 64'(irq), 64'd0);
        check("midrst_ack", 64'(ack), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wb_read(32'h3000_0010, rd); check("busy_after_rst", 64'(rd), 64'd0);
        wb_read(32'h3000_0008, rd); check("done_after_rst", 64'(rd), 64'd0);
        wb_read(32'h3000_0000, rd); check("mode_after_rst", 64'(rd), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/user_proj_example_wb.md
Name: user_proj_example_wb

Overview:
- Caravel user-project block: a Wishbone-slave nearest-patch search engine.
- Host loads a 6-level KD tree (63 internal nodes, 64 leaves of 8 patches each) and a set of query patches over Wishbone, then starts the engine.
- For each query, the engine descends the tree to one leaf and picks the L1-closest leaf patch.
- Host reads back one 11-bit best-match index per query.

Parameters:
- BITS, 32, Wishbone data width.
- DATA_WIDTH, 11, pixel/index width.
- LEAF_SIZE, 8, patches per leaf.
- PATCH_SIZE, 5, rows per patch; each row holds 5 pixels.
- NUM_LEAVES, 64, leaves; NUM_NODES = NUM_LEAVES-1.
- NUM_QUERYS, 494, query patches.

Ports:
- wb_clk_i in 1: sole clock.
- wb_rst_i in 1: asynchronous, active-high reset.
- wbs_stb_i in 1: Wishbone strobe.
- wbs_cyc_i in 1: Wishbone cycle.
- wbs_we_i in 1: write enable.
- wbs_sel_i in 4: byte selects; ignored, full-word access.
- wbs_dat_i in 32: write data.
- wbs_adr_i in 32: address.
- wbs_ack_o out 1: acknowledge.
- wbs_dat_o out 32: read data.
- la_data_in in 128: unused.
- la_data_out out 128: driven 0.
- la_oenb in 128: unused.
- io_in in 38: unused.
- io_out out 38: [31]=done, [30]=busy, all other bits 0.
- io_oeb out 38: [31:30]=0, all other bits 1.
- irq out 3: [0]=done, [2:1]=0.

Behaviour:
- Reset values:
  - ack=0, dat_o=0, MODE=0, DEBUG=0, done=0, busy=0, all outputs at the values above.
  - Memory contents are not cleared by reset.
- Wishbone transaction:
  - A transaction is cyc&stb while ack=0; ack rises on the next clock for exactly one cycle.
  - If stb stays high, the next transaction may start the cycle after ack falls.
  - Writes commit on the ack cycle.
  - Read data appears with ack and dat_o holds until the next read ack.
- Address decode uses adr&FFFF_0000. Unmapped addresses still ack; reads return 0 and writes are ignored.
- Register block 3000_xxxx:
  - 0x00 MODE: bit0, rw.
  - 0x04 DEBUG: bit0, rw.
  - 0x08 DONE: ro.
  - 0x0C FSM_START: any write starts the engine if not busy.
  - 0x10 BUSY: ro.
  - Other offsets read 0.
- 3001_xxxx query memory, write-only:
  - Row word w=adr[14:3], valid w < NUM_QUERYS*5; w=q*5+row.
  - adr[2]=0 writes bits[31:0] of the 64-bit row; adr[2]=1 writes bits[63:32].
  - Pixel c (0..4) is in bits [11c+10:11c].
- 3002_xxxx leaf memory, write-only:
  - Same addressing and pixel layout; w=((leaf*8+slot)*5+row), valid w < 2560.
  - Bits [63:55] = 9-bit patch index; only row 0's index is used.
- 3004_xxxx node memory, write-only:
  - Node n=adr[5:0] (1..63); n=0 is ignored.
  - dat[10:0] = element index e (0..24), dat[21:11] = median.
- 3003_xxxx best memory, read-only:
  - Query q=adr[14:3]; returns {21'b0, best[q]} regardless of adr[2].
- All memory writes are ignored while busy.
- Engine FSM: IDLE -> (start) SEARCH -> DIST -> NEXT -> SEARCH ..., then DONE back to IDLE.
  - Start clears done, sets busy, and sets q=0.
  - SEARCH:
    - Starting at n=1, do 6 steps.
    - Each step reads query pixel row e/5, column e%5.
    - If the pixel < median (unsigned), n=2n; otherwise n=2n+1.
    - The resulting leaf is n-64.
  - DIST:
    - For slots 0..7, compute the sum over 25 pixels of |query-leaf| in a 16-bit accumulator.
    - Keep the minimum with strict <, so on a tie the lowest slot wins.
    - Write best[q] = {2'b0, idx of the winning slot}.
  - NEXT: q++; after q=NUM_QUERYS-1, busy=0 and done=1 (sticky until the next start or reset).
  - Throughput requirement: at most 64 cycles per query.
- Start while busy is ignored. Reset mid-run returns to IDLE with busy=done=0; best memory contents are then undefined.
- MODE and DEBUG have no functional effect beyond readback.

Test Plan:
- Reset; write DEBUG=1 and MODE=1, read both -> 1; read DONE and BUSY -> 0; every access acks exactly one cycle.
- Load all nodes with e=0, median=0 (all queries go right, leaf 63). Leaf 63: slot 3 equals query 0 with idx=0x1A5, other slots differ by ≥1 pixel. Start -> busy=1 then done=1 and io_out[31]=1; read 3003_0000 -> 0x1A5.
- All nodes median=2047; query pixels < 2047 -> leaf 0. Leaf 0 slots 2 and 5 at equal minimum distance -> best = slot 2's idx.
- Write to 3004_0000 (n=0), 3005_0000, and query memory while busy -> ack, no state change; reading 3005_0000 -> 0.
- Assert wb_rst_i mid-run -> busy=0, done=0, ack=0 immediately.
- Full 494-query run -> done within 494*64 cycles of start; every best entry matches the software model.
